// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// A parallel-loaded word is walked LSB first, one bit per clock: bits are
// copied up to and including the first 1, and the remaining bits are inverted
// when the operand is negative. Non-negative operands pass through unchanged.
//
// Handshake: start is sampled only in IDLE. din is captured on the edge that
// accepts start. busy is high for the W cycles of SHIFT. done is a
// one-cycle pulse in DONE. mag/sign are updated on the edge that enters DONE
// and then hold until the next completion.
module twos_to_signmag_serial #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] din,
   output logic         busy,
   output logic         done,
   output logic         sign,
   output logic [W-1:0] mag
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   work;
   logic [W-1:0]   acc;
   logic [CW-1:0]  cnt;
   logic           found;
   logic           sign_r;
   logic           out_bit;
   logic           last_bit;

   // Current bit after the copy/invert rule; last_bit marks the W-th bit.
   always_comb begin
      out_bit  = work[0] ^ (sign_r & found);
      last_bit = (cnt == LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load on accept, shift one bit per SHIFT cycle, publish result
   // on the final bit so mag/sign never change mid-conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work   <= '0;
         acc    <= '0;
         cnt    <= '0;
         found  <= 1'b0;
         sign_r <= 1'b0;
         sign   <= 1'b0;
         mag    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work   <= din;
                  acc    <= '0;
                  sign_r <= din[W-1];
                  found  <= 1'b0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               work  <= work >> 1;
               acc   <= {out_bit, acc[W-1:1]};
               found <= found | work[0];
               cnt   <= cnt + CW'(1);
               if (last_bit) begin
                  mag  <= {out_bit, acc[W-1:1]};
                  sign <= sign_r;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status flags decode directly from the state register.
   always_comb begin
      busy = (state == SHIFT);
      done = (state == DONE);
   end

endmodule
